exhaustive_stim_capture: RTL and testbench

- Upstream/downstream harness stage for the trojan-detection benchmark flow.
- Drives every N_IN-bit input pattern into a single-output DUT and waits a programmable settle time.
- Samples the DUT output and pushes {pattern, response} records into a small FIFO, drained over a valid/ready stream.
- Folds every response into a MISR signature so a full sweep is reduced to one compact word.

---
 rtl/stim_capture_pkg.sv | 27 ++
 rtl/exhaustive_stim_capture_if.sv | 25 ++
 rtl/stim_rec_fifo.sv | 62 ++++++
 rtl/exhaustive_stim_capture.sv | 152 +++++++++++++++
 tb/tb_exhaustive_stim_capture.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/stim_capture_pkg.sv
// Shared types and constants for the exhaustive stimulus/capture harness stage.
// Optional Gray-code sweep order is selected by STIM_CAPTURE_GRAY_EN in the top.
package stim_capture_pkg;

    // Sweep controller states
    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        WAIT,
        SAMPLE,
        STALL,
        DONE
    } state_t;

    // Default MISR width and its feedback polynomial (CRC-16-CCITT taps)
    localparam int              DEFAULT_SIG_W = 16;
    localparam logic [15:0]     MISR_POLY     = 16'h1021;

    // Record layout as seen by a consumer: applied pattern plus captured response
    localparam int REC_PATTERN_W = 6;

    typedef struct packed {
        logic [REC_PATTERN_W-1:0] pattern;
        logic                     resp;
    } rec_t;

endpackage

// File: rtl/exhaustive_stim_capture_if.sv
// Record stream between the capture stage (master) and its consumer (slave).
interface exhaustive_stim_capture_if #(
    parameter int N_IN = 6
) ();

    logic            rec_valid;
    logic            rec_ready;
    logic [N_IN-1:0] rec_pattern;
    logic            rec_resp;

    modport master (
        output rec_valid,
        output rec_pattern,
        output rec_resp,
        input  rec_ready
    );

    modport slave (
        input  rec_valid,
        input  rec_pattern,
        input  rec_resp,
        output rec_ready
    );

endinterface

// File: rtl/stim_rec_fifo.sv
// Small synchronous FIFO with registered full/empty flags.
// Head data reads as zero while empty so the stream outputs are clean after reset.
module stim_rec_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             do_push;
    logic             do_pop;

    // A push while full is dropped here; the producer sees full and retries
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign count_next = count + (AW+1)'(do_push) - (AW+1)'(do_pop);

    // Pointers, occupancy and the registered flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/exhaustive_stim_capture.sv
// Exhaustive stimulus/capture stage: sweeps every N_IN-bit pattern into a
// single-output DUT, records {pattern, response} into a FIFO and folds each
// response into a MISR signature.
// Define STIM_CAPTURE_GRAY_EN to apply the patterns in Gray-code order.
module exhaustive_stim_capture
    import stim_capture_pkg::*;
#(
    parameter int N_IN       = 6,
    parameter int SETTLE     = 1,
    parameter int FIFO_DEPTH = 8,
    parameter int SIG_W      = DEFAULT_SIG_W
) (
    input  logic                       CK,
    input  logic                       reset,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [N_IN-1:0]            stim_out,
    input  logic                       dut_resp,
    exhaustive_stim_capture_if.master  rec_if,
    output logic [SIG_W-1:0]           signature
);

    localparam int              REC_W        = N_IN + 1;
    localparam logic [N_IN-1:0] LAST_PATTERN = '1;
    localparam logic [SIG_W-1:0] POLY        = SIG_W'(MISR_POLY);
    localparam logic [3:0]      SETTLE_LD    = 4'(SETTLE);

    state_t            state;
    state_t            state_next;
    logic [N_IN-1:0]   counter;
    logic [3:0]        settle_cnt;
    logic              captured;
    logic              accept;
    logic              push;
    logic              sample_bit;
    logic              fifo_full;
    logic              fifo_empty;
    logic [REC_W-1:0]  push_data;
    logic [REC_W-1:0]  head_data;
    logic              misr_fb;
    logic [SIG_W-1:0]  misr_next;

`ifdef STIM_CAPTURE_GRAY_EN
    assign stim_out = counter ^ (counter >> 1);
`else
    assign stim_out = counter;
`endif

    // In SAMPLE the live response is used; in STALL the bit captured earlier
    assign accept     = start && ((state == IDLE) || (state == DONE));
    assign sample_bit = (state == SAMPLE) ? dut_resp : captured;
    assign push       = ((state == SAMPLE) || (state == STALL)) && !fifo_full;
    assign push_data  = {stim_out, sample_bit};

    assign misr_fb   = signature[SIG_W-1] ^ sample_bit;
    assign misr_next = {signature[SIG_W-2:0], 1'b0} ^ (misr_fb ? POLY : '0);

    // State register
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: the sweep ends on the push of the all-ones counter value
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = APPLY;
                end
            end
            APPLY: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (settle_cnt < 4'd2) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE, STALL: begin
                if (push) begin
                    state_next = (counter == LAST_PATTERN) ? DONE : APPLY;
                end else begin
                    state_next = STALL;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sweep datapath: pattern counter, settle timer, held response, status, MISR
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            counter    <= '0;
            settle_cnt <= '0;
            captured   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            signature  <= '1;
        end else begin
            if (accept) begin
                counter   <= '0;
                signature <= '1;
                busy      <= 1'b1;
                done      <= 1'b0;
            end
            if (state == APPLY) begin
                settle_cnt <= SETTLE_LD;
            end else if (state == WAIT) begin
                settle_cnt <= settle_cnt - 4'd1;
            end
            if (state == SAMPLE) begin
                captured <= dut_resp;
            end
            if (push) begin
                signature <= misr_next;
                if (counter == LAST_PATTERN) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    counter <= counter + N_IN'(1);
                end
            end
        end
    end

    stim_rec_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk   (CK),
        .rst_n (reset),
        .push  (push),
        .wdata (push_data),
        .pop   (rec_if.rec_ready),
        .rdata (head_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rec_if.rec_valid   = !fifo_empty;
    assign rec_if.rec_pattern = head_data[REC_W-1:1];
    assign rec_if.rec_resp    = head_data[0];

endmodule

// File: tb/tb_exhaustive_stim_capture.sv
// Bench for exhaustive_stim_capture: table of full sweeps plus hand-written
// restart and mid-sweep reset sequences, with a record scoreboard and MISR model.
// Honours STIM_CAPTURE_GRAY_EN for the expected pattern order.
module tb_exhaustive_stim_capture;
    import stim_capture_pkg::*;

    localparam int N_IN  = 6;
    localparam int NPAT  = 64;
    localparam int SIG_W = 16;

    logic              CK = 1'b0;
    logic              reset;
    logic              start;
    logic              busy;
    logic              done;
    logic [N_IN-1:0]   stim_out;
    logic              dut_resp;
    logic [SIG_W-1:0]  signature;
    int                resp_mode;

    exhaustive_stim_capture_if #(.N_IN(N_IN)) rec_if ();

    exhaustive_stim_capture #(
        .N_IN       (N_IN),
        .SETTLE     (1),
        .FIFO_DEPTH (8),
        .SIG_W      (SIG_W)
    ) dut (
        .CK        (CK),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .stim_out  (stim_out),
        .dut_resp  (dut_resp),
        .rec_if    (rec_if),
        .signature (signature)
    );

    always #5 CK = ~CK;

    typedef struct {
        int mode;
        int hold;
        int exp_ones;
        int exp_cyc;
    } vec_t;

    vec_t             vectors [4];
    logic [SIG_W-1:0] sigs [4];

    int               errors = 0;
    int               checks = 0;
    rec_t             exp_q [$];
    logic [SIG_W-1:0] exp_sig;
    int               popped;
    int               ones_seen;
    int               distinct;
    bit               seen [NPAT];

    // Pattern applied at sweep step k
    function automatic logic [N_IN-1:0] pat_of(input int k);
        logic [N_IN-1:0] b;
        b = N_IN'(k);
`ifdef STIM_CAPTURE_GRAY_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    // DUT model: 0 = parity, 1 = trojan trigger on 101101, otherwise constant 0
    function automatic logic resp_of(input int mode, input logic [N_IN-1:0] p);
        case (mode)
            0:       return ^p;
            1:       return (p == 6'b101101);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [SIG_W-1:0] misr_ref(input logic [SIG_W-1:0] s, input logic r);
        logic fb;
        fb = s[SIG_W-1] ^ r;
        return {s[SIG_W-2:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    assign dut_resp = resp_of(resp_mode, stim_out);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Load the scoreboard with the whole expected sweep, then pulse start
    task automatic applyStimulus();
        rec_t r;
        exp_q.delete();
        popped    = 0;
        ones_seen = 0;
        distinct  = 0;
        for (int k = 0; k < NPAT; k++) seen[k] = 1'b0;
        exp_sig = 16'hFFFF;
        for (int k = 0; k < NPAT; k++) begin
            r.pattern = pat_of(k);
            r.resp    = resp_of(resp_mode, r.pattern);
            exp_q.push_back(r);
            exp_sig = misr_ref(exp_sig, r.resp);
        end
        start = 1'b1;
        @(posedge CK);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(output int cyc);
        cyc = 0;
        while (!done && cyc < 4000) begin
            @(posedge CK);
            #1;
            cyc++;
        end
        checkOutput("done_seen", done, 1);
    endtask

    // Wait for done, drain the FIFO, and compare sweep totals and signature
    task automatic finishSweep(input int cyc_offset, input int exp_cyc, input int exp_ones);
        int cyc;
        int n;
        waitDone(cyc);
        if (exp_cyc > 0) checkOutput("done_latency", cyc + cyc_offset, exp_cyc);
        checkOutput("busy_after_done", busy, 0);
        checkOutput("stim_hold_last", stim_out, pat_of(NPAT - 1));
        n = 0;
        while ((rec_if.rec_valid || exp_q.size() != 0) && n < 100) begin
            @(posedge CK);
            #1;
            n++;
        end
        checkOutput("sb_drained", exp_q.size(), 0);
        checkOutput("record_count", popped, NPAT);
        checkOutput("distinct_patterns", distinct, NPAT);
        checkOutput("ones_count", ones_seen, exp_ones);
        checkOutput("signature", signature, exp_sig);
    endtask

    // Scoreboard monitor: a handshake seen here completes on the next rising edge
    always @(negedge CK) begin : monitor
        rec_t e;
        if (reset === 1'b1 && rec_if.rec_valid === 1'b1 && rec_if.rec_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("sb_unexpected_record", rec_if.rec_pattern, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                checkOutput("sb_pattern", rec_if.rec_pattern, e.pattern);
                checkOutput("sb_resp", rec_if.rec_resp, e.resp);
            end
            popped++;
            if (rec_if.rec_resp) ones_seen++;
            if (!seen[rec_if.rec_pattern]) begin
                seen[rec_if.rec_pattern] = 1'b1;
                distinct++;
            end
        end
    end

    // Main sequence
    initial begin
        int n;
        vectors[0] = '{0, 0,  32, 192};
        vectors[1] = '{1, 0,  1,  192};
        vectors[2] = '{2, 0,  0,  192};
        vectors[3] = '{0, 40, 32, 0};

        reset            = 1'b0;
        start            = 1'b0;
        resp_mode        = 0;
        rec_if.rec_ready = 1'b1;
        repeat (3) @(posedge CK);
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_stim", stim_out, 0);
        checkOutput("rst_valid", rec_if.rec_valid, 0);
        checkOutput("rst_pattern", rec_if.rec_pattern, 0);
        checkOutput("rst_resp", rec_if.rec_resp, 0);
        checkOutput("rst_signature", signature, 16'hFFFF);
        reset = 1'b1;
        @(posedge CK);
        #1;

        for (int i = 0; i < 4; i++) begin
            resp_mode        = vectors[i].mode;
            rec_if.rec_ready = (vectors[i].hold == 0);
            applyStimulus();
            if (vectors[i].hold > 0) begin
                repeat (vectors[i].hold) @(posedge CK);
                #1;
                checkOutput("stall_stim_frozen", stim_out, pat_of(8));
                checkOutput("stall_state", 32'(dut.state), 32'(STALL));
                checkOutput("stall_busy", busy, 1);
                checkOutput("stall_head_valid", rec_if.rec_valid, 1);
                checkOutput("stall_head_pattern", rec_if.rec_pattern, pat_of(0));
                rec_if.rec_ready = 1'b1;
            end
            finishSweep(0, vectors[i].exp_cyc, vectors[i].exp_ones);
            sigs[i] = signature;
        end
        checkOutput("trojan_sig_differs", sigs[1] != sigs[2], 1);

        // start while busy is ignored; start after done restarts cleanly
        resp_mode        = 0;
        rec_if.rec_ready = 1'b1;
        applyStimulus();
        repeat (49) @(posedge CK);
        #1;
        start = 1'b1;
        @(posedge CK);
        #1;
        start = 1'b0;
        checkOutput("ignored_start_busy", busy, 1);
        finishSweep(50, 192, 32);
        applyStimulus();
        checkOutput("restart_signature", signature, 16'hFFFF);
        checkOutput("restart_stim", stim_out, pat_of(0));
        checkOutput("restart_done_clr", done, 0);
        checkOutput("restart_busy", busy, 1);
        finishSweep(0, 192, 32);

        // Reset asserted mid-sweep, then a clean sweep afterwards
        applyStimulus();
        n = 0;
        while (stim_out != pat_of(20) && n < 200) begin
            @(posedge CK);
            #1;
            n++;
        end
        checkOutput("reached_pattern20", stim_out, pat_of(20));
        reset = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_stim", stim_out, 0);
        checkOutput("midrst_valid", rec_if.rec_valid, 0);
        checkOutput("midrst_pattern", rec_if.rec_pattern, 0);
        checkOutput("midrst_resp", rec_if.rec_resp, 0);
        checkOutput("midrst_signature", signature, 16'hFFFF);
        exp_q.delete();
        repeat (2) @(posedge CK);
        #1;
        reset = 1'b1;
        @(posedge CK);
        #1;
        applyStimulus();
        finishSweep(0, 192, 32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
